// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with a posted, coalescing
// FIFO write buffer in front of the backing array.
//   CLK        in   sole clock, rising edge
//   RESET      in   synchronous active-high reset (buffer only, array kept)
//   daddr      in   word address from the MEM stage
//   ddata_w    in   store data
//   mem_write  in   store request
//   mem_read   in   load request
//   ddata_r    out  load data, combinational; 0 when mem_read is low
//   wbuf_count out  write-buffer occupancy
//   wbuf_full  out  occupancy equals WBUF_DEPTH
module data_mem_responder #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADDR_SIZE  = 10,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [ADDR_SIZE-1:0]          daddr,
    input  logic [DATA_SIZE-1:0]          ddata_w,
    input  logic                          mem_write,
    input  logic                          mem_read,
    output logic [DATA_SIZE-1:0]          ddata_r,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          wbuf_full
);

    localparam int unsigned PTR_W     = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_SIZE;

    // Backing array and buffer state
    logic [DATA_SIZE-1:0] mem_q   [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] addr_q  [WBUF_DEPTH];
    logic [ADDR_SIZE-1:0] addr_d  [WBUF_DEPTH];
    logic [DATA_SIZE-1:0] data_q  [WBUF_DEPTH];
    logic [DATA_SIZE-1:0] data_d  [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 full;
    logic                 drain;
    logic                 push;
    logic                 coal_hit;
    logic [PTR_W-1:0]     coal_idx;
    logic                 fwd_hit;
    logic [DATA_SIZE-1:0] fwd_data;

    assign full       = (count_q == CNT_W'(WBUF_DEPTH));
    assign wbuf_count = count_q;
    assign wbuf_full  = full;

    // Drain whenever the array port is free, or forcibly when full
    assign drain = (count_q != '0) && (!mem_read || full);

    // Coalesce target: a live entry with the same address that is not leaving this edge
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == daddr) &&
                !(drain && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    assign push = mem_write && !coal_hit;

    // Forwarding scan in logical age order: later (newer) matches override older
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && valid_q[idx] && (addr_q[idx] == daddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    // Load data path: pre-edge state only, so same-cycle stores are invisible
    always_comb begin
        ddata_r = '0;
        if (mem_read) begin
            ddata_r = fwd_hit ? fwd_data : mem_q[daddr];
        end
    end

    // Buffer next state; on a full push+drain the tail slot is the head slot,
    // so the valid clear must come before the valid set
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (mem_write && coal_hit) begin
            data_d[coal_idx] = ddata_w;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            addr_d[tail_q]  = daddr;
            data_d[tail_q]  = ddata_w;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Array write port; reset blocks the drain so pending stores are discarded
    always_ff @(posedge CLK) begin
        if (!RESET && drain) begin
            mem_q[addr_q[head_q]] <= data_q[head_q];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
module tb_data_mem_responder;

    logic        CLK;
    logic        RESET;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] ddata_r;
    logic [2:0]  wbuf_count;
    logic        wbuf_full;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(
        .DATA_SIZE (32),
        .ADDR_SIZE (10),
        .WBUF_DEPTH(4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .daddr     (daddr),
        .ddata_w   (ddata_w),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .ddata_r   (ddata_r),
        .wbuf_count(wbuf_count),
        .wbuf_full (wbuf_full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d);
        mem_write = w;
        mem_read  = r;
        daddr     = a;
        ddata_w   = d;
    endtask

    task automatic test_reset();
        // Preload array[5] through the port, then reset: array survives
        drive(1'b1, 1'b0, 10'd5, 32'h5555_0005);
        step();
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        #1;
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", wbuf_count); end
        n_checks++;
        if (wbuf_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", wbuf_full); end
        n_checks++;
        if (ddata_r !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_idle: got %h expected 0", ddata_r); end
        drive(1'b0, 1'b1, 10'd5, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h5555_0005) begin n_fail++; $display("FAIL reset_read5: got %h expected 55550005", ddata_r); end
    endtask

    task automatic test_forward();
        drive(1'b1, 1'b0, 10'd3, 32'hAAAA_0001);
        step();
        drive(1'b0, 1'b1, 10'd3, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'hAAAA_0001) begin n_fail++; $display("FAIL fwd_read3: got %h expected aaaa0001", ddata_r); end
        n_checks++;
        if (wbuf_count !== 3'd1) begin n_fail++; $display("FAIL fwd_count: got %0d expected 1", wbuf_count); end
        step();
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        step();
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL fwd_drained: got %0d expected 0", wbuf_count); end
        drive(1'b0, 1'b1, 10'd3, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'hAAAA_0001) begin n_fail++; $display("FAIL fwd_array3: got %h expected aaaa0001", ddata_r); end
    endtask

    task automatic test_coalesce();
        drive(1'b0, 1'b1, 10'd5, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h5555_0005) begin n_fail++; $display("FAIL b2b_read5: got %h expected 55550005", ddata_r); end
        step();
        drive(1'b0, 1'b1, 10'd3, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_read3: got %h expected aaaa0001", ddata_r); end
        step();
        drive(1'b1, 1'b1, 10'd1, 32'h11);
        step();
        drive(1'b1, 1'b1, 10'd2, 32'h22);
        step();
        drive(1'b1, 1'b1, 10'd1, 32'h33);
        #1;
        // Same-cycle store is not visible: read sees the buffered 0x11
        n_checks++;
        if (ddata_r !== 32'h11) begin n_fail++; $display("FAIL coal_prestore: got %h expected 11", ddata_r); end
        step();
        n_checks++;
        if (wbuf_count !== 3'd2) begin n_fail++; $display("FAIL coal_count: got %0d expected 2", wbuf_count); end
        drive(1'b0, 1'b1, 10'd1, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h33) begin n_fail++; $display("FAIL coal_read1: got %h expected 33", ddata_r); end
        drive(1'b0, 1'b1, 10'd2, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h22) begin n_fail++; $display("FAIL coal_read2: got %h expected 22", ddata_r); end
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        step();
        step();
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL coal_drained: got %0d expected 0", wbuf_count); end
        drive(1'b0, 1'b1, 10'd1, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h33) begin n_fail++; $display("FAIL coal_array1: got %h expected 33", ddata_r); end
        drive(1'b0, 1'b1, 10'd2, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h22) begin n_fail++; $display("FAIL coal_array2: got %h expected 22", ddata_r); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 10'(10 + i), 32'(256 + 10 + i));
            step();
        end
        n_checks++;
        if (wbuf_count !== 3'd4) begin n_fail++; $display("FAIL full_count4: got %0d expected 4", wbuf_count); end
        n_checks++;
        if (wbuf_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %0b expected 1", wbuf_full); end
        drive(1'b1, 1'b1, 10'd14, 32'h10E);
        step();
        n_checks++;
        if (wbuf_count !== 3'd4) begin n_fail++; $display("FAIL full_count5: got %0d expected 4", wbuf_count); end
        n_checks++;
        if (dut.mem_q[10] !== 32'h10A) begin n_fail++; $display("FAIL full_forced_drain10: got %h expected 10a", dut.mem_q[10]); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 10'(10 + i), 32'h0);
            #1;
            n_checks++;
            if (ddata_r !== 32'(256 + 10 + i)) begin
                n_fail++;
                $display("FAIL full_read%0d: got %h expected %h", 10 + i, ddata_r, 32'(256 + 10 + i));
            end
            step();
        end
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", wbuf_count); end
    endtask

    task automatic test_head_match();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 10'(20 + i), 32'(512 + i));
            step();
        end
        n_checks++;
        if (wbuf_full !== 1'b1) begin n_fail++; $display("FAIL head_full: got %0b expected 1", wbuf_full); end
        drive(1'b1, 1'b1, 10'd20, 32'h55);
        #1;
        n_checks++;
        if (ddata_r !== 32'h200) begin n_fail++; $display("FAIL head_prestore: got %h expected 200", ddata_r); end
        step();
        n_checks++;
        if (wbuf_count !== 3'd4) begin n_fail++; $display("FAIL head_count: got %0d expected 4", wbuf_count); end
        n_checks++;
        if (dut.mem_q[20] !== 32'h200) begin n_fail++; $display("FAIL head_old_drained: got %h expected 200", dut.mem_q[20]); end
        drive(1'b0, 1'b1, 10'd20, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h55) begin n_fail++; $display("FAIL head_fwd_new: got %h expected 55", ddata_r); end
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL head_drained: got %0d expected 0", wbuf_count); end
        drive(1'b0, 1'b1, 10'd20, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h55) begin n_fail++; $display("FAIL head_array20: got %h expected 55", ddata_r); end
        drive(1'b0, 1'b1, 10'd21, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'h201) begin n_fail++; $display("FAIL head_array21: got %h expected 201", ddata_r); end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 10'(30 + i), 32'(32'hA30 + i));
            step();
        end
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 10'(30 + i), 32'(32'hB30 + i));
            step();
        end
        n_checks++;
        if (wbuf_count !== 3'd3) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 3", wbuf_count); end
        drive(1'b0, 1'b1, 10'd31, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'hB31) begin n_fail++; $display("FAIL rst_pre_fwd31: got %h expected b31", ddata_r); end
        RESET = 1'b1;
        drive(1'b1, 1'b0, 10'd33, 32'hDEAD);
        step();
        RESET = 1'b0;
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        #1;
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", wbuf_count); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 10'(30 + i), 32'h0);
            #1;
            n_checks++;
            if (ddata_r !== 32'(32'hA30 + i)) begin
                n_fail++;
                $display("FAIL rst_read%0d: got %h expected %h", 30 + i, ddata_r, 32'(32'hA30 + i));
            end
        end
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        step();
        step();
        n_checks++;
        if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL rst_count_later: got %0d expected 0", wbuf_count); end
        drive(1'b0, 1'b1, 10'd33, 32'h0);
        #1;
        n_checks++;
        if (ddata_r !== 32'hA33) begin n_fail++; $display("FAIL rst_discard33: got %h expected a33", ddata_r); end
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 32'h0);
        step();
        step();
        RESET = 1'b0;
        test_reset();
        test_forward();
        test_coalesce();
        test_full();
        test_head_match();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
